pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage in-order pipeline.
- Watches the instruction in ID, the ID/EX register contents (rd, mem_read, valid) and the data-memory handshake in MEM.
- Drives per-stage hold/bubble/flush enables: load-use bubbles, taken-branch squash, whole-pipe freeze on memory wait.
- Keeps a memory-wait timeout FSM plus saturating performance counters.

Parameters:
- CNT_W, 32: width of stall_cnt and flush_cnt.
- MEM_TIMEOUT, 256: consecutive MEM_WAIT cycles before mem_err is raised; 2..2^16-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_valid  in  1  ID/EX register valid bit.
- ex_rd  in  5  ID/EX destination register.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle.
- mem_req  in  1  MEM stage issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  PC holds.
- ifid_stall  out  1  IF/ID register holds.
- ifid_flush  out  1  IF/ID register loads valid=0.
- idex_stall  out  1  ID/EX register holds.
- idex_bubble  out  1  ID/EX register loads valid=0 and all control bits 0.
- exmem_stall  out  1  EX/MEM register holds.
- memwb_bubble  out  1  MEM/WB register loads valid=0.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  cycles with pc_stall=1.
- flush_cnt  out  CNT_W  redirects accepted.

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - State=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
  - While rst_n=0 all combinational control outputs are 0.
- Control outputs: combinational from current state and inputs, same cycle. Counters, state and mem_err are registered.
- freeze = mem_req & ~mem_ready, in state RUN or MEM_WAIT.
- load_use = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Output priority, highest first:
  - ERROR: pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble = 1; all else 0.
  - freeze: same set = 1. ex_redirect and load_use are ignored; EX and ID are held and re-evaluated after release.
  - ex_redirect: ifid_flush=1, idex_bubble=1, pc_stall=0. A simultaneous load_use is dropped because ID is wrong-path.
  - load_use: pc_stall=1, ifid_stall=1, idex_bubble=1. Exactly one bubble per load; the next cycle the load sits in EX/MEM, so load_use is clear.
  - Otherwise all outputs 0.
- FSM:
  - RUN -> MEM_WAIT when freeze. wait_cnt becomes 1.
  - MEM_WAIT: while freeze, wait_cnt++. On mem_ready (or mem_req dropping) -> RUN, wait_cnt=0; release happens in that same cycle, so outputs are 0 unless another hazard applies.
  - MEM_WAIT -> ERROR when freeze and wait_cnt==MEM_TIMEOUT-1. mem_err=1 from the next cycle.
  - ERROR is terminal until reset.
- Counters:
  - stall_cnt += 1 on each cycle with pc_stall=1.
  - flush_cnt += 1 on each cycle in which the ex_redirect branch of the priority is taken.
  - Both saturate at 2^CNT_W-1; no wrap.
- ex_rd==0 never creates a hazard.

Test Plan:
- Load-use bubble: ex_valid=1, ex_mem_read=1, ex_rd=5; id_valid=1, id_uses_rs1=1, id_rs1=5 -> same cycle pc_stall=ifid_stall=idex_bubble=1. Next cycle (ex_mem_read=0) all 0. stall_cnt=1.
- x0 and unused-operand cases:
  - ex_rd=0 with id_rs1=0 -> no stall.
  - ex_rd=7 with id_rs2=7 but id_uses_rs2=0 -> no stall.
- Redirect beats load-use: ex_redirect=1 together with the load-use condition -> ifid_flush=idex_bubble=1, pc_stall=0, flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> freeze outputs high for 3 cycles, 0 on the ready cycle, state back in RUN, stall_cnt=3. An ex_redirect asserted during the wait produces no ifid_flush.
- Timeout (MEM_TIMEOUT=4): mem_req=1, mem_ready never asserts -> mem_err=1 after the 4th wait cycle and stays high after mem_ready=1. rst_n pulse low mid-ERROR -> mem_err=0, counters 0, outputs 0 immediately without a clock.
- Saturation (CNT_W=4): hold load-use for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage in-order pipeline: load-use bubbles,
// redirect squash, memory-wait freeze with timeout FSM and performance counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_wait_cnt;
  logic [15:0]      w_wait_cnt_next;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_freeze;
  logic             w_load_use;
  logic             w_redirect_taken;
  logic [1:0]       w_src_used;
  logic [4:0]       w_src_reg [2];
  logic [1:0]       w_src_hit;

  logic w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall;
  logic w_idex_bubble, w_exmem_stall, w_memwb_bubble;

  assign w_src_used   = {id_uses_rs2, id_uses_rs1};
  assign w_src_reg[0] = id_rs1;
  assign w_src_reg[1] = id_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_hit
      assign w_src_hit[gi] = w_src_used[gi] & (w_src_reg[gi] == ex_rd);
    end
  endgenerate

  // x0 is hardwired zero, so a load targeting it can never be a real producer.
  assign w_load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid & (|w_src_hit);
  assign w_freeze   = mem_req & ~mem_ready & (r_state != ERROR);

  always_comb begin
    w_pc_stall       = 1'b0;
    w_ifid_stall     = 1'b0;
    w_ifid_flush     = 1'b0;
    w_idex_stall     = 1'b0;
    w_idex_bubble    = 1'b0;
    w_exmem_stall    = 1'b0;
    w_memwb_bubble   = 1'b0;
    w_redirect_taken = 1'b0;
    if (rst_n) begin
      if ((r_state == ERROR) || w_freeze) begin
        w_pc_stall     = 1'b1;
        w_ifid_stall   = 1'b1;
        w_idex_stall   = 1'b1;
        w_exmem_stall  = 1'b1;
        w_memwb_bubble = 1'b1;
      end else if (ex_redirect) begin
        // Any load-use seen now belongs to a wrong-path instruction in ID.
        w_ifid_flush     = 1'b1;
        w_idex_bubble    = 1'b1;
        w_redirect_taken = 1'b1;
      end else if (w_load_use) begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_freeze) begin
          w_state_next    = MEM_WAIT;
          w_wait_cnt_next = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (!w_freeze) begin
          w_state_next    = RUN;
          w_wait_cnt_next = 16'd0;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_next = ERROR;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 16'd1;
        end
      end
      ERROR: begin
        w_state_next = ERROR;
      end
      default: begin
        w_state_next    = RUN;
        w_wait_cnt_next = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= 16'd0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_mem_err  <= (w_state_next == ERROR);
    end
  end

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect_taken && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_stall     = w_pc_stall;
  assign ifid_stall   = w_ifid_stall;
  assign ifid_flush   = w_ifid_flush;
  assign idex_stall   = w_idex_stall;
  assign idex_bubble  = w_idex_bubble;
  assign exmem_stall  = w_exmem_stall;
  assign memwb_bubble = w_memwb_bubble;
  assign mem_err      = r_mem_err;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with CNT_W=4, MEM_TIMEOUT=4.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // Control bundle order: pc_stall, ifid_stall, ifid_flush, idex_stall,
  // idex_bubble, exmem_stall, memwb_bubble.
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_FRZ  = 7'b1101011;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_RD   = 7'b0010100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_valid, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic             pc_stall, ifid_stall, ifid_flush, idex_stall;
  logic             idex_bubble, exmem_stall, memwb_bubble, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0]       ctl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble};

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_bubble(idex_bubble), .exmem_stall(exmem_stall),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0h expected=%0h", n_vec, tag, obs, exp);
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_valid = 1; ex_mem_read = 1; ex_rd = rd;
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = rd; id_uses_rs2 = 0; id_rs2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 0;
    #2;
    chk("reset_ctl", 32'(ctl), 32'(C_NONE));
    chk("reset_mem_err", 32'(mem_err), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    mem_req = 1;
    #1;
    chk("reset_gates_freeze", 32'(ctl), 32'(C_NONE));
    mem_req = 0;
    #10 rst_n = 1;
    tick();

    // Load-use through rs1, then the load has moved on.
    set_load_use(5'd5);
    #1 chk("lu_rs1", 32'(ctl), 32'(C_LU));
    tick();
    ex_mem_read = 0;
    #1 chk("lu_release", 32'(ctl), 32'(C_NONE));
    chk("lu_stall_cnt", 32'(stall_cnt), 1);

    // x0 producer and unused-operand match never stall.
    set_load_use(5'd0);
    #1 chk("x0_no_stall", 32'(ctl), 32'(C_NONE));
    ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_uses_rs2 = 0;
    #1 chk("rs2_unused", 32'(ctl), 32'(C_NONE));
    id_uses_rs2 = 1;
    #1 chk("lu_rs2", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_rs2_cnt", 32'(stall_cnt), 2);

    // Redirect beats load-use.
    set_load_use(5'd9);
    ex_redirect = 1;
    #1 chk("redirect_wins", 32'(ctl), 32'(C_RD));
    tick();
    chk("redirect_flush_cnt", 32'(flush_cnt), 1);
    chk("redirect_stall_cnt", 32'(stall_cnt), 2);

    // Memory wait of three cycles, redirect and load-use ignored meanwhile.
    idle();
    mem_req = 1;
    #1 chk("mw_frz1", 32'(ctl), 32'(C_FRZ));
    tick();
    set_load_use(5'd4);
    ex_redirect = 1;
    #1 chk("mw_frz2_redirect", 32'(ctl), 32'(C_FRZ));
    tick();
    #1 chk("mw_frz3", 32'(ctl), 32'(C_FRZ));
    tick();
    idle();
    mem_req = 1; mem_ready = 1;
    #1 chk("mw_release", 32'(ctl), 32'(C_NONE));
    tick();
    chk("mw_stall_cnt", 32'(stall_cnt), 5);
    chk("mw_flush_cnt", 32'(flush_cnt), 1);
    chk("mw_no_err", 32'(mem_err), 0);

    // Timeout: four wait cycles from RUN reach ERROR.
    mem_ready = 0;
    #1 chk("to_frz", 32'(ctl), 32'(C_FRZ));
    tick(); chk("to_err_w1", 32'(mem_err), 0);
    tick(); chk("to_err_w2", 32'(mem_err), 0);
    tick(); chk("to_err_w3", 32'(mem_err), 0);
    tick(); chk("to_err_w4", 32'(mem_err), 1);
    mem_ready = 1;
    #1 chk("err_ready_still_frz", 32'(ctl), 32'(C_FRZ));
    tick();
    chk("err_sticky", 32'(mem_err), 1);
    idle();
    ex_redirect = 1;
    #1 chk("err_ignores_redirect", 32'(ctl), 32'(C_FRZ));
    tick();
    chk("err_stall_cnt", 32'(stall_cnt), 11);
    chk("err_flush_cnt", 32'(flush_cnt), 1);

    // Asynchronous reset mid-ERROR, checked with no clock edge in between.
    mem_req = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_mem_err", 32'(mem_err), 0);
    chk("arst_stall_cnt", 32'(stall_cnt), 0);
    chk("arst_flush_cnt", 32'(flush_cnt), 0);
    chk("arst_ctl", 32'(ctl), 32'(C_NONE));
    idle();
    #2 rst_n = 1;
    tick();
    #1 chk("post_reset_run", 32'(ctl), 32'(C_NONE));

    // Saturation: 20 load-use cycles with a 4-bit counter.
    set_load_use(5'd12);
    #1 chk("sat_lu", 32'(ctl), 32'(C_LU));
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat_cnt14", 32'(stall_cnt), 14);
    end
    chk("sat_cnt_final", 32'(stall_cnt), 15);
    chk("sat_flush_cnt", 32'(flush_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
